mlp_mac_unit: RTL and testbench
===============================

MLP_MAC_UNIT -- requirements
Module: mlp_mac_unit

Interface
REQ-001 SHALL define parameter DATA_W, default 16: signed Q8.8 operand and result width.
REQ-002 SHALL define parameter ADDR_W, default 12: neuron memory address width.
REQ-003 SHALL define parameter ACC_W, default 42: accumulator width, holds 1024 full-scale products without overflow.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on posedge, while the sequencer drives inputs on negedge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port run  in  1: low = synchronous clear of all state.
REQ-007 SHALL have port sample_en  in  1: the neuron_data/weight_data pair is valid this cycle.
REQ-008 SHALL have port neuron_data  in  DATA_W: input activation, signed Q8.8.
REQ-009 SHALL have port weight_data  in  DATA_W: weight, signed Q8.8.
REQ-010 SHALL have port last_term  in  1: this pair is the final term of the current neuron (from write_neuron).
REQ-011 SHALL have port reset_mult_acc  in  1: flush the accumulator and pipeline.
REQ-012 SHALL have port output_neuron_addr  in  ADDR_W: destination address, sampled with last_term.
REQ-013 SHALL have port last_layer  in  1: the current neuron belongs to the output layer.
REQ-014 SHALL have port done  in  1: the sequencer has issued its final term.
REQ-015 SHALL have port wr_en  out  1: one-cycle neuron memory write strobe.
REQ-016 SHALL have port wr_addr  out  ADDR_W: write address.
REQ-017 SHALL have port wr_data  out  DATA_W: activated result, Q8.8.
REQ-018 SHALL have port wr_count  out  ADDR_W: number of writes since the last clear.
REQ-019 SHALL have port mlp_done  out  1: sticky flag, all results written.

Function
REQ-020 SHALL be a 3-stage pipeline. S1 registers a DATA_W x DATA_W signed product (Q16.16) with last, addr and last_layer, on sample_en only. S2 accumulates. S3 rounds, activates, saturates and writes.
REQ-021 SHALL assert wr_en exactly 3 cycles after the clock edge that samples a last_term=1 pair, with wr_addr equal to the output_neuron_addr sampled with that pair.
REQ-022 SHALL pass acc+product to S3 in S2 when last is set, and load 0 into the accumulator, so back-to-back neurons need no bubble.
REQ-023 SHALL round by adding 0x80 then arithmetic-shifting right by 8, then saturate to [0x8000, 0x7FFF].
REQ-024 SHALL give clear priority when reset_mult_acc and sample_en are asserted together: the accumulator and all stage valid bits are cleared, and the sample is dropped.
REQ-025 SHALL ignore sample_en=0 cycles, which insert bubbles without changing accumulator state.
REQ-026 SHALL latch done into a pending flag; mlp_done SHALL rise the cycle after the S1, S2 and S3 valid bits are all zero while pending is set, and hold until run=0 or reset.
REQ-027 SHALL increment wr_count on each wr_en, wrapping at 2^ADDR_W.
REQ-028 SHALL clear all state on run=0 at the next posedge, with identical values to reset.

Reset
REQ-029 SHALL, on rst_n=0, immediately drive wr_en=0, wr_addr=0, wr_data=0, wr_count=0 and mlp_done=0, and clear the accumulator, valid bits and done-pending, regardless of clk.
REQ-030 SHALL produce no write for any neuron in flight when reset is asserted mid-accumulation; after release, the first write requires new samples.

Configuration
REQ-031 SHALL apply ReLU (negative result becomes 0x0000) in S3 when MLP_MAC_RELU_EN is defined and last_layer=0, and pass the output layer through unchanged for softmax.
REQ-032 SHALL be identity activation for all layers without MLP_MAC_RELU_EN.

Structure
REQ-033 SHALL take DATA_W, ADDR_W, ACC_W, FRAC_BITS=8 and the Q8.8 min/max constants from the shared package mlp_pkg.
REQ-034 SHALL implement round, shift and saturate in the combinational sub-module mlp_round_sat, instantiated once in S3.

Verification
REQ-035 SHALL cover: 4 pairs of 0x0100 x 0x0100, last on the 4th, addr 0x401 -> wr_en 3 cycles later, wr_addr=0x401, wr_data=0x0400, wr_count=1.
REQ-036 SHALL cover: 4 pairs of 0x7FFF x 0x7FFF -> wr_data=0x7FFF; 4 pairs of 0x8000 x 0x7FFF, last_layer=1 -> 0x8000.
REQ-037 SHALL cover: 1 pair 0xFF00 x 0x0100 with last_layer=0 -> 0x0000 with the macro, 0xFF00 without it; with last_layer=1 -> 0xFF00 in both builds.
REQ-038 SHALL cover: 0x0001 x 0x0080 (product 0x80) -> wr_data=0x0001; 0x0001 x 0x007F -> 0x0000.
REQ-039 SHALL cover: done pulsed together with the last term of the output neuron -> mlp_done rises 1 cycle after that neuron's wr_en and holds until run=0.
REQ-040 SHALL cover: rst_n pulled low between 2 of 4 terms -> outputs 0 immediately, no wr_en afterward; repeat with reset_mult_acc pulsed alongside sample_en -> that sample is dropped.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared constants for the MLP datapath: Q8.8 operand format, neuron memory
// addressing and accumulator sizing, plus the ReLU helper used by the MAC.
package mlp_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int ACC_W     = 42;
  localparam int FRAC_BITS = 8;

  // Q8.8 saturation limits
  localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

  // Negative activations clamp to zero, positive pass through
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/mlp_round_sat.sv
// Combinational Q16.16 -> Q8.8 conversion: round half up, arithmetic shift,
// then saturate to the signed Q8.8 range.
module mlp_round_sat
  import mlp_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = DATA_W
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic signed [OUT_W-1:0] result
);

  localparam int SH_W = IN_W - FRAC_BITS;
  localparam logic signed [IN_W-1:0] HALF   = IN_W'(1 << (FRAC_BITS - 1));
  localparam logic signed [SH_W-1:0] SAT_HI = SH_W'(Q_MAX);
  localparam logic signed [SH_W-1:0] SAT_LO = SH_W'(Q_MIN);

  logic signed [IN_W-1:0] biased;
  logic signed [SH_W-1:0] shifted;

  // Round, drop the extra fraction bits and clamp into the output range
  always_comb begin
    biased  = sum + HALF;
    shifted = SH_W'(biased >>> FRAC_BITS);
    result  = OUT_W'(shifted);
    if (shifted > SAT_HI) begin
      result = OUT_W'(Q_MAX);
    end else if (shifted < SAT_LO) begin
      result = OUT_W'(Q_MIN);
    end
  end

endmodule

// File: rtl/mlp_mac_unit.sv
// MLP multiply-accumulate unit: S1 multiply, S2 accumulate, S3 round/activate,
// then a registered neuron-memory write port.
// Optional build macro: MLP_MAC_RELU_EN enables ReLU on hidden layers.
module mlp_mac_unit #(
  parameter int DATA_W = mlp_pkg::DATA_W,
  parameter int ADDR_W = mlp_pkg::ADDR_W,
  parameter int ACC_W  = mlp_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] neuron_data,
  input  logic [DATA_W-1:0] weight_data,
  input  logic              last_term,
  input  logic              reset_mult_acc,
  input  logic [ADDR_W-1:0] output_neuron_addr,
  input  logic              last_layer,
  input  logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_count,
  output logic              mlp_done
);

  import mlp_pkg::*;

`ifdef MLP_MAC_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  // S1 registers
  logic                       s1_valid_reg;
  logic signed [2*DATA_W-1:0] s1_prod_reg;
  logic                       s1_last_reg;
  logic                       s1_ll_reg;
  logic [ADDR_W-1:0]          s1_addr_reg;
  // S2 registers
  logic                       s2_valid_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [ACC_W-1:0]    s2_sum_reg;
  logic                       s2_ll_reg;
  logic [ADDR_W-1:0]          s2_addr_reg;
  // S3 registers
  logic                       s3_valid_reg;
  logic [DATA_W-1:0]          s3_data_reg;
  logic [ADDR_W-1:0]          s3_addr_reg;
  logic                       done_pending_reg;

  logic signed [2*DATA_W-1:0] prod_next;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum_next;
  logic signed [DATA_W-1:0]   rounded;
  logic [DATA_W-1:0]          activated;
  logic                       pipe_empty;

  assign prod_next  = (2*DATA_W)'($signed(neuron_data)) * (2*DATA_W)'($signed(weight_data));
  assign prod_ext   = ACC_W'(s1_prod_reg);
  assign sum_next   = acc_reg + prod_ext;
  assign pipe_empty = !s1_valid_reg && !s2_valid_reg && !s3_valid_reg;

  mlp_round_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_round_sat (
    .sum    (s2_sum_reg),
    .result (rounded)
  );

  // Output layer bypasses ReLU so softmax sees signed logits
  assign activated = (RELU_EN && !s2_ll_reg) ? relu(rounded) : rounded;

  // S1: capture the product and its neuron tags on each valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_prod_reg  <= '0;
      s1_last_reg  <= 1'b0;
      s1_ll_reg    <= 1'b0;
      s1_addr_reg  <= '0;
    end else if (!run) begin
      s1_valid_reg <= 1'b0;
      s1_prod_reg  <= '0;
      s1_last_reg  <= 1'b0;
      s1_ll_reg    <= 1'b0;
      s1_addr_reg  <= '0;
    end else if (reset_mult_acc) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= sample_en;
      if (sample_en) begin
        s1_prod_reg <= prod_next;
        s1_last_reg <= last_term;
        s1_ll_reg   <= last_layer;
        s1_addr_reg <= output_neuron_addr;
      end
    end
  end

  // S2: accumulate; on the last term hand the total on and restart from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      acc_reg      <= '0;
      s2_sum_reg   <= '0;
      s2_ll_reg    <= 1'b0;
      s2_addr_reg  <= '0;
    end else if (!run) begin
      s2_valid_reg <= 1'b0;
      acc_reg      <= '0;
      s2_sum_reg   <= '0;
      s2_ll_reg    <= 1'b0;
      s2_addr_reg  <= '0;
    end else if (reset_mult_acc) begin
      s2_valid_reg <= 1'b0;
      acc_reg      <= '0;
    end else if (s1_valid_reg && s1_last_reg) begin
      s2_valid_reg <= 1'b1;
      s2_sum_reg   <= sum_next;
      acc_reg      <= '0;
      s2_ll_reg    <= s1_ll_reg;
      s2_addr_reg  <= s1_addr_reg;
    end else begin
      s2_valid_reg <= 1'b0;
      if (s1_valid_reg) begin
        acc_reg <= sum_next;
      end
    end
  end

  // S3: register the rounded, activated result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_reg <= 1'b0;
      s3_data_reg  <= '0;
      s3_addr_reg  <= '0;
    end else if (!run) begin
      s3_valid_reg <= 1'b0;
      s3_data_reg  <= '0;
      s3_addr_reg  <= '0;
    end else if (reset_mult_acc) begin
      s3_valid_reg <= 1'b0;
    end else begin
      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        s3_data_reg <= activated;
        s3_addr_reg <= s2_addr_reg;
      end
    end
  end

  // Write port: one-cycle strobe per finished neuron, counting writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_count <= '0;
    end else if (!run) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_count <= '0;
    end else begin
      wr_en <= s3_valid_reg;
      if (s3_valid_reg) begin
        wr_addr  <= s3_addr_reg;
        wr_data  <= s3_data_reg;
        wr_count <= wr_count + ADDR_W'(1);
      end
    end
  end

  // Completion: remember done, raise mlp_done once the pipeline drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_pending_reg <= 1'b0;
      mlp_done         <= 1'b0;
    end else if (!run) begin
      done_pending_reg <= 1'b0;
      mlp_done         <= 1'b0;
    end else begin
      if (done) begin
        done_pending_reg <= 1'b1;
      end
      if (done_pending_reg && pipe_empty) begin
        mlp_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mlp_mac_unit.sv
// Self-checking bench for mlp_mac_unit: directed corner cases plus random
// neurons, checked every cycle against a behavioural model of the unit.
// Build with MLP_MAC_RELU_EN defined to check the ReLU variant.
module tb_mlp_mac_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        sample_en;
  logic [15:0] neuron_data;
  logic [15:0] weight_data;
  logic        last_term;
  logic        reset_mult_acc;
  logic [11:0] output_neuron_addr;
  logic        last_layer;
  logic        done;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [11:0] wr_count;
  logic        mlp_done;

  always #5 clk = ~clk;

  mlp_mac_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .run                (run),
    .sample_en          (sample_en),
    .neuron_data        (neuron_data),
    .weight_data        (weight_data),
    .last_term          (last_term),
    .reset_mult_acc     (reset_mult_acc),
    .output_neuron_addr (output_neuron_addr),
    .last_layer         (last_layer),
    .done               (done),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_count           (wr_count),
    .mlp_done           (mlp_done)
  );

`ifdef MLP_MAC_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  typedef struct {
    int          due;
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t     exp_q[$];
  longint  acc_m;
  int      cyc;
  int      cnt_m;
  bit      pend_m;
  int      pend_at;
  int      busy_until;
  bit      done_m;
  logic [15:0] seen_data;
  logic [11:0] seen_addr;
  logic [11:0] seen_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Q16.16 sum -> Q8.8 with round-half-up, clamp and optional ReLU
  function automatic logic [15:0] model_out(input longint s, input bit ll);
    longint r;
    logic [63:0] bits;
    r = (s + 128) >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    if (RELU_ON && !ll && r < 0) r = 0;
    bits = 64'(r);
    return bits[15:0];
  endfunction

  task automatic model_clear();
    acc_m      = 0;
    exp_q.delete();
    cnt_m      = 0;
    pend_m     = 1'b0;
    done_m     = 1'b0;
    busy_until = -1000;
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 ns later
  task automatic step(input bit se, input logic [15:0] nd, input logic [15:0] wd,
                      input bit last, input logic [11:0] addr, input bit ll,
                      input bit dn, input bit rma, input bit rn);
    bit exp_wr;
    wr_t w;
    @(negedge clk);
    sample_en          = se;
    neuron_data        = nd;
    weight_data        = wd;
    last_term          = last;
    output_neuron_addr = addr;
    last_layer         = ll;
    done               = dn;
    reset_mult_acc     = rma;
    run                = rn;
    @(posedge clk);
    cyc++;
    exp_wr = 1'b0;
    if (!rn) begin
      model_clear();
    end else begin
      if (pend_m && pend_at <= cyc - 1 && busy_until <= cyc - 2) done_m = 1'b1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        w = exp_q.pop_front();
        exp_wr = 1'b1;
        cnt_m++;
      end
      if (dn && !pend_m) begin
        pend_m  = 1'b1;
        pend_at = cyc;
      end
      if (rma) begin
        acc_m = 0;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
        if (busy_until > cyc - 1) busy_until = cyc - 1;
      end else if (se) begin
        acc_m += longint'($signed(nd)) * longint'($signed(wd));
        if (last) begin
          exp_q.push_back('{due: cyc + 3, addr: addr, data: model_out(acc_m, ll)});
          acc_m = 0;
          busy_until = cyc + 2;
        end else if (busy_until < cyc) begin
          busy_until = cyc;
        end
      end
    end
    #1;
    check("wr_en", 64'(wr_en), 64'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 64'(wr_addr), 64'(w.addr));
      check("wr_data", 64'(wr_data), 64'(w.data));
    end
    check("wr_count", 64'(wr_count), 64'(12'(cnt_m)));
    check("mlp_done", 64'(mlp_done), 64'(done_m));
    if (wr_en) begin
      seen_data  = wr_data;
      seen_addr  = wr_addr;
      seen_count = wr_count;
      $display("[TB] cycle %0d write addr=0x%03h data=0x%04h count=%0d", cyc, wr_addr, wr_data, wr_count);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pair(input logic [15:0] nd, input logic [15:0] wd, input bit last,
                      input logic [11:0] addr, input bit ll);
    step(1'b1, nd, wd, last, addr, ll, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic neuron(input int terms, input logic [15:0] nd, input logic [15:0] wd,
                        input logic [11:0] addr, input bit ll);
    for (int i = 0; i < terms; i++) pair(nd, wd, (i == terms - 1), addr, ll);
    idle(4);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"},    64'(wr_en),    64'(0));
    check({tag, "_wr_addr"},  64'(wr_addr),  64'(0));
    check({tag, "_wr_data"},  64'(wr_data),  64'(0));
    check({tag, "_wr_count"}, 64'(wr_count), 64'(0));
    check({tag, "_mlp_done"}, 64'(mlp_done), 64'(0));
  endtask

  initial begin
    cyc = 0;
    model_clear();
    rst_n = 1'b0; run = 1'b0; sample_en = 1'b0; neuron_data = '0; weight_data = '0;
    last_term = 1'b0; reset_mult_acc = 1'b0; output_neuron_addr = '0; last_layer = 1'b0;
    done = 1'b0;
    #23;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Basic accumulation: 4 x 1.0 * 1.0 = 4.0
    seen_data = 16'hDEAD;
    neuron(4, 16'h0100, 16'h0100, 12'h401, 1'b0);
    check("dir_basic_data",  64'(seen_data),  64'(16'h0400));
    check("dir_basic_addr",  64'(seen_addr),  64'(12'h401));
    check("dir_basic_count", 64'(seen_count), 64'(1));

    // Saturation both ways
    neuron(4, 16'h7FFF, 16'h7FFF, 12'h010, 1'b0);
    check("dir_sat_hi", 64'(seen_data), 64'(16'h7FFF));
    neuron(4, 16'h8000, 16'h7FFF, 12'h011, 1'b1);
    check("dir_sat_lo", 64'(seen_data), 64'(16'h8000));

    // Activation on a negative result, hidden vs output layer
    neuron(1, 16'hFF00, 16'h0100, 12'h020, 1'b0);
    check("dir_act_hidden", 64'(seen_data), 64'(RELU_ON ? 16'h0000 : 16'hFF00));
    neuron(1, 16'hFF00, 16'h0100, 12'h021, 1'b1);
    check("dir_act_output", 64'(seen_data), 64'(16'hFF00));

    // Rounding boundary
    neuron(1, 16'h0001, 16'h0080, 12'h030, 1'b1);
    check("dir_round_up", 64'(seen_data), 64'(16'h0001));
    neuron(1, 16'h0001, 16'h007F, 12'h031, 1'b1);
    check("dir_round_down", 64'(seen_data), 64'(16'h0000));

    // Back-to-back neurons without a bubble
    pair(16'h0100, 16'h0200, 1'b1, 12'h040, 1'b1);
    pair(16'h0100, 16'h0300, 1'b1, 12'h041, 1'b1);
    idle(4);
    check("dir_b2b_data", 64'(seen_data), 64'(16'h0300));

    // Asynchronous reset mid-neuron: in-flight terms are lost
    pair(16'h0100, 16'h0100, 1'b0, 12'h050, 1'b1);
    pair(16'h0100, 16'h0100, 1'b0, 12'h050, 1'b1);
    @(negedge clk);
    sample_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    pair(16'h0100, 16'h0100, 1'b0, 12'h051, 1'b1);
    pair(16'h0100, 16'h0100, 1'b1, 12'h051, 1'b1);
    idle(4);
    check("dir_rst_data", 64'(seen_data), 64'(16'h0200));

    // Flush together with a sample: the sample and prior terms are dropped
    pair(16'h0100, 16'h0100, 1'b0, 12'h060, 1'b1);
    pair(16'h0100, 16'h0100, 1'b0, 12'h060, 1'b1);
    step(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 12'h060, 1'b1, 1'b0, 1'b1, 1'b1);
    pair(16'h0200, 16'h0100, 1'b0, 12'h061, 1'b1);
    pair(16'h0200, 16'h0100, 1'b1, 12'h061, 1'b1);
    idle(4);
    check("dir_flush_data", 64'(seen_data), 64'(16'h0400));

    // Random neurons with bubbles
    for (int n = 0; n < 40; n++) begin
      int terms;
      bit ll;
      logic [11:0] addr;
      terms = $urandom_range(1, 6);
      ll    = 1'($urandom_range(0, 1));
      addr  = 12'($urandom);
      for (int t = 0; t < terms; t++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        pair(16'($urandom), 16'($urandom), (t == terms - 1), addr, ll);
      end
    end
    idle(5);

    // done with the final term, then drain, then clear via run
    pair(16'h0100, 16'h0100, 1'b0, 12'h070, 1'b1);
    step(1'b1, 16'h0100, 16'h0100, 1'b1, 12'h070, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    idle(1);
    check("dir_done_wr", 64'(wr_en), 64'(1));
    check("dir_done_not_yet", 64'(mlp_done), 64'(0));
    idle(1);
    check("dir_done_rise", 64'(mlp_done), 64'(1));
    idle(3);
    step(1'b0, 16'h0, 16'h0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outputs_zero("run_clear");
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
